// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory-backed slave: single slave with no HSEL, wait states, byte/half/word
// lanes and a two-cycle ERROR response for illegal accesses.
// Optional random wait states: define AHB_SLV_RAND_WAIT_EN.
module ahb_lite_mem_slave #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          hready_n;
    logic [1:0]    hresp_n;
    logic [3:0]    wait_cnt;

    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   offset;
    logic          in_range, size_ok, active, legal, illegal;
    logic [AW-1:0] idx;
    logic [3:0]    strb;

    logic          wr_pend;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_strb;
    logic [31:0]   wr_word;
    logic [31:0]   rd_word;

    logic          unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0]};

    // Address-phase decode: range, size and alignment legality plus lane strobes
    always_comb begin
        offset   = HADDR - BASE_ADDR;
        in_range = (HADDR >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
        active   = HTRANS[1];
        idx      = offset[AW+1:2];
        size_ok  = 1'b0;
        strb     = 4'b0000;
        case (HSIZE)
            3'b000: begin
                size_ok = 1'b1;
                strb    = 4'b0001 << offset[1:0];
            end
            3'b001: begin
                size_ok = ~offset[0];
                strb    = offset[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                size_ok = (offset[1:0] == 2'b00);
                strb    = 4'b1111;
            end
            default: begin
                size_ok = 1'b0;
                strb    = 4'b0000;
            end
        endcase
        legal   = active & in_range & size_ok;
        illegal = active & ~(in_range & size_ok);
    end

    // Pending write merged with the stored word; also the read-forwarding source
    always_comb begin
        wr_word = mem[wr_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) begin
                wr_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
        rd_word = (wr_pend && (wr_idx == idx)) ? wr_word : mem[idx];
    end

`ifdef AHB_SLV_RAND_WAIT_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1 LFSR, advanced once per accepted legal transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lfsr <= 8'hA5;
        end else if (HREADY && legal) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_cnt = {2'b00, lfsr[1:0]};
`else
    assign wait_cnt = 4'(WAIT_STATES);
`endif

    // Next state and next-cycle HREADY/HRESP; IDLE and ERR2 both sample an address phase
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hready_n = 1'b1;
        hresp_n  = RESP_OKAY;
        unique case (state)
            S_IDLE, S_ERR2: begin
                state_n = S_IDLE;
                if (illegal) begin
                    state_n  = S_ERR1;
                    hready_n = 1'b0;
                    hresp_n  = RESP_ERR;
                end else if (legal && (wait_cnt != 4'd0)) begin
                    state_n  = S_WAIT;
                    cnt_n    = wait_cnt;
                    hready_n = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = S_IDLE;
                end else begin
                    hready_n = 1'b0;
                end
            end
            S_ERR1: begin
                state_n = S_ERR2;
                hresp_n = RESP_ERR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, response outputs and address-phase capture (only while HREADY is high)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            HREADY  <= 1'b1;
            HRESP   <= RESP_OKAY;
            HRDATA  <= 32'd0;
            wr_pend <= 1'b0;
            wr_idx  <= '0;
            wr_strb <= 4'b0000;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            HREADY <= hready_n;
            HRESP  <= hresp_n;
            if (HREADY) begin
                wr_pend <= legal & HWRITE;
                wr_idx  <= idx;
                wr_strb <= strb;
                if (legal && !HWRITE) begin
                    HRDATA <= rd_word;
                end
            end
        end
    end

    // Memory array: a write commits on the edge that completes its data phase
    always_ff @(posedge HCLK) begin
        if (HREADY && wr_pend) begin
            mem[wr_idx] <= wr_word;
        end
    end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite memory-backed slave: the responder end of the bus that the testbench driver initiates on.
- Single-slave system with no HSEL decoding; the slave drives the shared HREADY, HRESP and HRDATA directly.
- Supports a programmable number of wait states, byte/halfword/word transfers, and a two-cycle ERROR response for illegal accesses.
- Used as the golden DUT/stand-in slave for the UVM environment.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; legal byte addresses are BASE_ADDR to BASE_ADDR+4*MEM_DEPTH-1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- WAIT_STATES, 0, HREADY-low cycles inserted per OKAY transfer (0..15).

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  reset, asynchronous, active-low
- HADDR  input  32  byte address (address phase)
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  input  1  1 = write
- HSIZE  input  3  000 byte, 001 halfword, 010 word
- HBURST  input  3  burst type; accepted but not checked
- HWDATA  input  32  write data (data phase)
- HREADY  output  1  transfer complete / slave ready
- HRESP  output  2  2'b00 OKAY, 2'b01 ERROR
- HRDATA  output  32  read data (data phase)

Behaviour:
- Reset (HRESETn=0, asynchronous):
  - HREADY=1, HRESP=00, HRDATA=0, FSM=IDLE.
  - Any pending write is dropped. Memory contents are not reset.
- Address phase: sampled on a rising edge of HCLK where HREADY=1.
  - Active transfer = HTRANS is 10 or 11. IDLE and BUSY get a zero-wait OKAY with no access.
  - Registered: address offset, HWRITE, HSIZE.
- Illegal transfer (any of):
  - HADDR outside the legal range.
  - HSIZE > 010.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0]!=00.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, legal active transfer with WAIT_STATES=0: stay IDLE; HREADY=1 next cycle (single-cycle data phase).
  - IDLE, legal active transfer with WAIT_STATES>0: go to WAIT and load the wait counter with WAIT_STATES. HREADY=0 while the counter is nonzero; the counter decrements each cycle. At 0, HREADY=1, HRESP=OKAY, return to IDLE (or accept the next address that same edge).
  - Illegal transfer: go to ERR1 (HREADY=0, HRESP=01), then ERR2 (HREADY=1, HRESP=01), then IDLE. No memory write occurs. The ERR2 edge samples the next address phase.
  - HRESP=00 in every state except ERR1 and ERR2.
- Writes:
  - Memory is updated on the edge that completes the data phase (HREADY=1), using HWDATA.
  - Byte lanes, little-endian: byte writes lane HADDR[1:0]; halfword writes lanes {HADDR[1],0}+1 and {HADDR[1],0}; word writes all four lanes. Other lanes are unchanged.
- Reads:
  - HRDATA is loaded with the full addressed word on the address-phase edge and held for the whole data phase, including wait states.
  - The master selects lanes.
  - HRDATA holds its value outside read data phases.
- Read-after-write hazard:
  - If a read address phase coincides with the completing edge of a write to the same word, HRDATA returns the merged value (new bytes forwarded, old bytes from memory).
  - Back-to-back transfers pipeline with zero bubbles when WAIT_STATES=0.
- During wait states the slave ignores HTRANS, HADDR, HWRITE and HSIZE. The master holds the next address phase.
- HBURST is ignored. Address wrap is the master's responsibility.

Optional Feature:
- Macro: AHB_SLV_RAND_WAIT_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances once per accepted legal active transfer.
  - That transfer's wait count = LFSR[1:0] (0..3), overriding WAIT_STATES.
- Undefined: the wait count is always WAIT_STATES and the LFSR logic is absent.

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 32'hDEADBEEF @0x10, then a read @0x10 on the next cycle -> read data phase HREADY=1, HRESP=00, HRDATA=32'hDEADBEEF (forwarding path).
2. Byte write 8'h5A @0x13 over word 32'h11223344 @0x10, then word read @0x10 -> HRDATA=32'h5A223344. Halfword write 16'hBEEF @0x12 -> 32'hBEEF3344.
3. WAIT_STATES=3: word read @0x20 -> HREADY low for exactly 3 cycles, then high with HRESP=00. HRDATA stable across all 4 data-phase cycles.
4. Word write @0x402 (MEM_DEPTH=256) -> ERR1: HREADY=0/HRESP=01, ERR2: HREADY=1/HRESP=01. A subsequent read of word @0x400 is also ERROR; a read @0x3FC shows memory unchanged.
5. Misaligned halfword @0x05 and HSIZE=011 each -> two-cycle ERROR. IDLE and BUSY transfers -> HREADY=1, HRESP=00, no memory change.
6. Assert HRESETn low during a WAIT-state write data phase -> HREADY=1 and HRESP=00 immediately, and the target word is unchanged after release.
